// File: rtl/spi_txn_arbiter_if.sv
`timescale 1ns/1ps
// Requester/engine bundle around the shared SPI byte engine.
// master: the arbiter side (drives grants, chip selects, engine strobes).
// slave: the requesters plus spi_master side (drives requests, bytes, engine status).
interface spi_txn_arbiter_if;
  // requester side
  logic [1:0]  req;
  logic [7:0]  len;
  logic [15:0] tx_data;
  logic [1:0]  gnt;
  logic [1:0]  tx_take;
  logic [7:0]  rx_data;
  logic [1:0]  rx_valid;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [1:0]  cs_n;
  // spi_master side
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_busy;
  logic        spi_new_data;
  logic [7:0]  spi_data_out;

  modport master (
    input  req, len, tx_data, spi_busy, spi_new_data, spi_data_out,
    output gnt, tx_take, rx_data, rx_valid, done, err, cs_n, spi_start, spi_data_in
  );

  modport slave (
    output req, len, tx_data, spi_busy, spi_new_data, spi_data_out,
    input  gnt, tx_take, rx_data, rx_valid, done, err, cs_n, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
`timescale 1ns/1ps
// Round-robin transaction arbiter sharing one spi_master byte engine between two requesters.
// Latency: grant 1 cycle after req; first spi_start CS_SETUP cycles later; done CS_HOLD+1 after last byte.
// Backpressure: launches wait while spi_busy is high; a watchdog aborts a byte that never completes.
module spi_txn_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1023
) (
  input logic               clk,
  input logic               rst,
  spi_txn_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  // The last SETUP cycle already acts as the launch cycle so the first
  // spi_start lands exactly CS_SETUP cycles after cs_n drops.
  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  // The exit from WAIT counts as the first hold cycle and RELEASE as the
  // last, so HOLD itself lasts CS_HOLD-1 cycles (none when CS_HOLD is 1).
  localparam logic [3:0] HOLD_LAST  = 4'((CS_HOLD > 1) ? (CS_HOLD - 2) : 0);
  localparam bit         SKIP_HOLD  = (CS_HOLD == 1);
  localparam logic [9:0] WD_LIMIT   = 10'(TIMEOUT);

  logic [2:0] state;
  logic [3:0] cnt;
  logic [3:0] rem;
  logic [9:0] wd;
  logic       sel;
  logic       last;
  logic       abort;

  logic       win;
  logic [1:0] win_oh;
  logic [3:0] win_len;
  logic [1:0] sel_oh;
  logic [7:0] tx_byte;
  logic       may_grant;
  logic       setup_end;
  logic       got_byte;
  logic       more;
  logic       timed_out;
  logic       want_launch;
  logic       fire;

  // Arbitration decision, byte selection and launch/complete/abort conditions.
  always_comb begin
    win         = (bus.req == 2'b11) ? ~last : bus.req[1];
    win_oh      = win ? 2'b10 : 2'b01;
    win_len     = win ? bus.len[7:4] : bus.len[3:0];
    sel_oh      = sel ? 2'b10 : 2'b01;
    tx_byte     = sel ? bus.tx_data[15:8] : bus.tx_data[7:0];
    // done is high only in the first IDLE cycle after RELEASE; blocking the
    // grant there guarantees an idle gap between back-to-back transactions.
    may_grant   = (state == S_IDLE) && (bus.req != 2'b00) && (bus.done == 2'b00);
    setup_end   = (state == S_SETUP) && (cnt == SETUP_LAST);
    got_byte    = (state == S_WAIT) && bus.spi_new_data;
    more        = got_byte && (rem != 4'd1);
    timed_out   = (state == S_WAIT) && !bus.spi_new_data && (wd == WD_LIMIT);
    want_launch = setup_end || (state == S_LAUNCH) || more;
    fire        = want_launch && !bus.spi_busy;
  end

  // Transaction sequencing: grant latch, setup/hold counting, byte countdown, abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      rem   <= 4'd0;
      sel   <= 1'b0;
      last  <= 1'b1;
      abort <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (may_grant) begin
            sel   <= win;
            last  <= win;
            rem   <= win_len;
            abort <= 1'b0;
            cnt   <= 4'd0;
            state <= (win_len == 4'd0) ? S_RELEASE : S_SETUP;
          end
        end
        S_SETUP: begin
          if (setup_end) begin
            state <= fire ? S_WAIT : S_LAUNCH;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_LAUNCH: begin
          if (fire) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (got_byte) begin
            rem <= rem - 4'd1;
            if (more) begin
              state <= fire ? S_WAIT : S_LAUNCH;
            end else begin
              state <= SKIP_HOLD ? S_RELEASE : S_HOLD;
              cnt   <= 4'd0;
            end
          end else if (timed_out) begin
            abort <= 1'b1;
            state <= SKIP_HOLD ? S_RELEASE : S_HOLD;
            cnt   <= 4'd0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_RELEASE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-byte watchdog: restarts on every launch, saturates at the limit while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= 10'd0;
    end else if (fire) begin
      wd <= 10'd0;
    end else if ((state == S_WAIT) && (wd != WD_LIMIT)) begin
      wd <= wd + 10'd1;
    end
  end

  // Registered requester/engine outputs: grants, chip selects, strobes and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt         <= 2'b00;
      bus.cs_n        <= 2'b11;
      bus.tx_take     <= 2'b00;
      bus.rx_data     <= 8'h00;
      bus.rx_valid    <= 2'b00;
      bus.done        <= 2'b00;
      bus.err         <= 2'b00;
      bus.spi_start   <= 1'b0;
      bus.spi_data_in <= 8'h00;
    end else begin
      bus.spi_start <= fire;
      bus.tx_take   <= fire ? sel_oh : 2'b00;
      bus.rx_valid  <= got_byte ? sel_oh : 2'b00;
      bus.done      <= (state == S_RELEASE) ? sel_oh : 2'b00;
      bus.err       <= ((state == S_RELEASE) && abort) ? sel_oh : 2'b00;
      if (fire) begin
        bus.spi_data_in <= tx_byte;
      end
      if (got_byte) begin
        bus.rx_data <= bus.spi_data_out;
      end
      if (may_grant) begin
        bus.gnt <= win_oh;
        // A zero-length transaction is granted for one cycle without touching cs_n.
        if (win_len != 4'd0) begin
          bus.cs_n <= ~win_oh;
        end
      end else if (state == S_RELEASE) begin
        bus.gnt  <= 2'b00;
        bus.cs_n <= 2'b11;
      end
    end
  end

endmodule
